// File: rtl/shift_in_collector.sv
// Serial-to-parallel collector: assembles LSB-first bits into a byte with a running ones count.
// Optional even-parity check of a 9th bit per frame is enabled with `define SHIFT_IN_PARITY_CHK_EN.
module shift_in_collector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       abort,
  output logic [7:0] word_out,
  output logic [3:0] ones_count,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       parity_err
);

`ifdef SHIFT_IN_PARITY_CHK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
`endif

  state_t     state;
  state_t     state_next;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [3:0] ones_reg;
  logic       accept;
  logic       clear;
  logic       shift_en;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    bit_ready  = (state != ST_HOLD);
    word_valid = (state == ST_HOLD);
    accept     = bit_valid && bit_ready;
    shift_en   = accept && !abort && ((state == ST_IDLE) || (state == ST_SHIFT));

    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (accept && (bit_cnt == 3'd7)) begin
`ifdef SHIFT_IN_PARITY_CHK_EN
          state_next = ST_PARITY;
`else
          state_next = ST_HOLD;
`endif
        end
      end
`ifdef SHIFT_IN_PARITY_CHK_EN
      ST_PARITY: begin
        if (accept) state_next = ST_HOLD;
      end
`endif
      ST_HOLD: begin
        if (word_ready) begin
          state_next = ST_IDLE;
          clear      = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        clear      = 1'b1;
      end
    endcase

    // Abort wins over any bit acceptance or word handshake in the same cycle.
    if (abort) begin
      state_next = ST_IDLE;
      clear      = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      ones_reg  <= 4'd0;
    end else if (clear) begin
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      ones_reg  <= 4'd0;
    end else if (shift_en) begin
      shift_reg <= {bit_in, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 3'd1;
      ones_reg  <= ones_reg + {3'b000, bit_in};
    end
  end

`ifdef SHIFT_IN_PARITY_CHK_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (clear) begin
      parity_reg <= 1'b0;
    end else if (accept && !abort && (state == ST_PARITY)) begin
      parity_reg <= (^shift_reg) ^ bit_in;
    end
  end

  assign parity_err = parity_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = shift_reg;
  assign ones_count = ones_reg;

endmodule
